// File: rtl/any1_fu_result_xmit.sv
// Per-FU result FIFOs feeding a round-robin arbiter and one output register toward the ROB.
// Latency: one cycle from push to rob_o; rob_rdy_i low holds rob_o and stops pops, fu_rdy_o drops when a FIFO fills.

module any1_fu_result_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         rdy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CAP = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt, cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (push && !pop)
      cnt_nxt = cnt + 1'b1;
    else if (pop && !push)
      cnt_nxt = cnt - 1'b1;
  end

  // rdy tracks the count that will hold after this edge, so it is a pure register
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      rdy  <= 1'b1;
    end else begin
      if (push)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      cnt <= cnt_nxt;
      rdy <= (cnt_nxt != CAP);
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wptr] <= din;
  end

  assign dout  = mem[rptr];
  assign empty = (cnt == '0);
endmodule

module any1_fu_result_xmit #(
  parameter int NPORT = 4,
  parameter int DEPTH = 2,
  // record layout, MSB first: cmt(1) rid(6) ele(4) res(64) cause(8) badAddr(32)
  localparam int FU_W = 1 + 6 + 4 + 64 + 8 + 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic [NPORT-1:0]      fu_v_i,
  output logic [NPORT-1:0]      fu_rdy_o,
  input  logic [NPORT*FU_W-1:0] fu_i,
  output logic                  rob_v_o,
  input  logic                  rob_rdy_i,
  output logic [FU_W-1:0]       rob_o,
  output logic                  busy_o
);
  localparam int LGW = (NPORT > 1) ? $clog2(NPORT) : 1;

  logic [NPORT-1:0] push, pop, empty;
  logic [FU_W-1:0]  head [NPORT];
  logic [LGW-1:0]   last_grant, gnt_idx;
  logic             gnt_any, load;
  int               p;

  assign push = fu_v_i & fu_rdy_o & {NPORT{~flush_i}};
  assign load = (!rob_v_o || rob_rdy_i) && !flush_i;

  for (genvar k = 0; k < NPORT; k++) begin : g_fifo
    any1_fu_result_fifo #(.W(FU_W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk_i),
      .rst   (rst_i),
      .clr   (flush_i),
      .push  (push[k]),
      .pop   (pop[k]),
      .din   (fu_i[k*FU_W +: FU_W]),
      .dout  (head[k]),
      .empty (empty[k]),
      .rdy   (fu_rdy_o[k])
    );
  end

  // first non-empty port searching upward from the one after the last winner
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    pop     = '0;
    p       = 0;
    for (int i = 0; i < NPORT; i++) begin
      p = (int'(last_grant) + 1 + i) % NPORT;
      if (!gnt_any && !empty[p]) begin
        gnt_any = 1'b1;
        gnt_idx = LGW'(p);
      end
    end
    if (gnt_any && load)
      pop[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rob_v_o    <= 1'b0;
      rob_o      <= '0;
      last_grant <= LGW'(NPORT - 1);
    end else if (flush_i) begin
      rob_v_o <= 1'b0;
    end else if (load) begin
      rob_v_o <= gnt_any;
      if (gnt_any) begin
        rob_o      <= head[gnt_idx];
        last_grant <= gnt_idx;
      end
    end
  end

  assign busy_o = rob_v_o || (~&empty);
endmodule

// File: tb/tb_any1_fu_result_xmit.sv
// Bench for any1_fu_result_xmit: directed scenarios plus a per-port scoreboard checked by a monitor.
module tb_any1_fu_result_xmit;
  localparam int NPORT = 4;
  localparam int FU_W  = 115;

  logic                  clk;
  logic                  rst_i, flush_i, rob_rdy_i;
  logic [NPORT-1:0]      fu_v_i;
  logic [NPORT-1:0]      fu_rdy_o;
  logic [NPORT*FU_W-1:0] fu_i;
  logic                  rob_v_o, busy_o;
  logic [FU_W-1:0]       rob_o;
  logic [FU_W-1:0]       fu_rec [NPORT];

  int n_tests = 0;
  int n_fail  = 0;
  logic [FU_W-1:0] q [NPORT][$];
  int delivered [NPORT];
  int mp;
  logic [FU_W-1:0] me;

  any1_fu_result_xmit #(.NPORT(NPORT), .DEPTH(2)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .flush_i   (flush_i),
    .fu_v_i    (fu_v_i),
    .fu_rdy_o  (fu_rdy_o),
    .fu_i      (fu_i),
    .rob_v_o   (rob_v_o),
    .rob_rdy_i (rob_rdy_i),
    .rob_o     (rob_o),
    .busy_o    (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    fu_i = '0;
    for (int k = 0; k < NPORT; k++)
      fu_i[k*FU_W +: FU_W] = fu_rec[k];
  end

  function automatic logic [FU_W-1:0] mk(input int port, input int rid, input logic [63:0] res,
                                         input logic [7:0] cause, input logic [31:0] bad, input logic cmt);
    return {cmt, 6'(rid), 4'(port), res, cause, bad};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sb;
    for (int k = 0; k < NPORT; k++)
      q[k].delete();
  endtask

  // monitor + scoreboard capture, evaluated mid-cycle ahead of the edge that commits the transfer
  initial for (int k = 0; k < NPORT; k++) delivered[k] = 0;
  always @(negedge clk) begin
    if (!rst_i) begin
      if (rob_v_o && rob_rdy_i) begin
        mp = int'(rob_o[105:104]);
        n_tests++;
        if (q[mp].size() == 0) begin
          n_fail++;
          $display("FAIL stray_record: got %0h on port %0d, expected nothing", rob_o, mp);
        end else begin
          me = q[mp].pop_front();
          delivered[mp]++;
          if (me !== rob_o) begin
            n_fail++;
            $display("FAIL rob_record: got %0h expected %0h", rob_o, me);
          end
        end
      end
      if (!flush_i)
        for (int k = 0; k < NPORT; k++)
          if (fu_v_i[k] && fu_rdy_o[k])
            q[k].push_back(fu_rec[k]);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int left [NPORT];
    int sent [NPORT];
    int base [NPORT];
    int guard;

    rst_i = 1'b1; flush_i = 1'b0; rob_rdy_i = 1'b0; fu_v_i = '0;
    for (int k = 0; k < NPORT; k++) fu_rec[k] = '0;
    tick; tick;
    check("rst_rob_v", rob_v_o, 0);
    check("rst_rob_o", rob_o, 0);
    check("rst_fu_rdy", fu_rdy_o, 4'hf);
    check("rst_busy", busy_o, 0);
    rst_i = 1'b0;

    // fairness straight out of reset: ports 0..3 in order
    rob_rdy_i = 1'b1;
    for (int k = 0; k < NPORT; k++) fu_rec[k] = mk(k, 10 + k, 64'(100 + k), 8'(k), 32'(k), 1'b1);
    fu_v_i = 4'hf;
    tick;
    fu_v_i = '0;
    check("fair_not_yet", rob_v_o, 0);
    for (int k = 0; k < NPORT; k++) begin
      tick;
      check("fair_v", rob_v_o, 1);
      check("fair_port", rob_o[105:104], k);
      check("fair_rid", rob_o[113:108], 10 + k);
    end
    tick;
    check("fair_idle", rob_v_o, 0);

    // single result on port 2
    fu_rec[2] = mk(2, 5, 64'h1234, 8'h0, 32'h0, 1'b1);
    fu_v_i = 4'b0100;
    tick;
    fu_v_i = '0;
    check("single_lat0", rob_v_o, 0);
    tick;
    check("single_v", rob_v_o, 1);
    check("single_rid", rob_o[113:108], 5);
    check("single_res", rob_o[103:40], 64'h1234);
    tick;
    check("single_gone", rob_v_o, 0);
    check("single_busy", busy_o, 0);

    // backpressure on port 1
    rob_rdy_i = 1'b0;
    fu_rec[1] = mk(1, 21, 64'hA, 8'h1, 32'hA0, 1'b0);
    fu_v_i = 4'b0010;
    tick;
    check("bp_rdy_a", fu_rdy_o[1], 1);
    fu_rec[1] = mk(1, 22, 64'hB, 8'h2, 32'hB0, 1'b1);
    tick;
    check("bp_hold_v", rob_v_o, 1);
    check("bp_rdy_b", fu_rdy_o[1], 1);
    fu_rec[1] = mk(1, 23, 64'hC, 8'h3, 32'hC0, 1'b0);
    tick;
    fu_v_i = '0;
    check("bp_full", fu_rdy_o[1], 0);
    check("bp_hold_rid", rob_o[113:108], 21);
    tick; tick;
    check("bp_still_rid", rob_o[113:108], 21);
    check("bp_still_full", fu_rdy_o[1], 0);
    rob_rdy_i = 1'b1;
    tick;
    check("bp_next_b", rob_o[113:108], 22);
    tick;
    check("bp_next_c", rob_o[113:108], 23);
    tick;
    check("bp_done", rob_v_o, 0);

    // flush with one held record and two buffered
    rob_rdy_i = 1'b0;
    fu_rec[0] = mk(0, 30, 64'h30, 8'h0, 32'h0, 1'b0);
    fu_rec[2] = mk(2, 32, 64'h32, 8'h0, 32'h0, 1'b0);
    fu_rec[3] = mk(3, 33, 64'h33, 8'h0, 32'h0, 1'b0);
    fu_v_i = 4'b1101;
    tick;
    fu_v_i = '0;
    tick;
    check("fl_pre_v", rob_v_o, 1);
    check("fl_pre_busy", busy_o, 1);
    flush_i = 1'b1; rob_rdy_i = 1'b1;
    fu_rec[1] = mk(1, 31, 64'h31, 8'h0, 32'h0, 1'b0);
    fu_v_i = 4'b0010;
    tick;
    flush_i = 1'b0; fu_v_i = '0;
    clear_sb();
    check("fl_v", rob_v_o, 0);
    check("fl_busy", busy_o, 0);
    check("fl_rdy", fu_rdy_o, 4'hf);
    for (int i = 0; i < 5; i++) begin
      tick;
      check("fl_quiet", rob_v_o, 0);
    end

    // reset while port 3 streams
    for (int i = 0; i < 8; i++) begin
      fu_rec[3] = mk(3, 50 + i, 64'(i), 8'(i), 32'(i), 1'b1);
      fu_v_i[3] = fu_rdy_o[3];
      rob_rdy_i = i[0];
      tick;
    end
    rst_i = 1'b1; fu_v_i = 4'b1000; rob_rdy_i = 1'b1;
    tick;
    rst_i = 1'b0; fu_v_i = '0;
    clear_sb();
    check("mrst_v", rob_v_o, 0);
    check("mrst_o", rob_o, 0);
    check("mrst_rdy", fu_rdy_o, 4'hf);
    check("mrst_busy", busy_o, 0);
    for (int k = 1; k < NPORT; k++) fu_rec[k] = mk(k, 60 + k, 64'(k), 8'h0, 32'h0, 1'b0);
    fu_v_i = 4'b1110;
    tick;
    fu_v_i = '0;
    for (int k = 1; k < NPORT; k++) begin
      tick;
      check("mrst_order", rob_o[105:104], k);
    end
    tick;
    check("mrst_idle", rob_v_o, 0);

    // random traffic, 100 records per port
    for (int k = 0; k < NPORT; k++) begin
      left[k] = 100; sent[k] = 0; base[k] = delivered[k];
    end
    guard = 0;
    while ((left[0] + left[1] + left[2] + left[3]) != 0 && guard < 3000) begin
      for (int k = 0; k < NPORT; k++) begin
        if (left[k] > 0 && fu_rdy_o[k] && $urandom_range(0, 1) == 1) begin
          fu_v_i[k] = 1'b1;
          fu_rec[k] = mk(k, sent[k], {$urandom, $urandom}, 8'($urandom), $urandom,
                         1'($urandom_range(0, 1)));
          sent[k]++;
          left[k]--;
        end else begin
          fu_v_i[k] = 1'b0;
        end
      end
      rob_rdy_i = ($urandom_range(0, 3) != 0);
      tick;
      guard++;
    end
    check("rnd_stim_timeout", guard < 3000, 1);
    fu_v_i = '0; rob_rdy_i = 1'b1;
    guard = 0;
    while (busy_o && guard < 200) begin
      tick;
      guard++;
    end
    check("rnd_drain", busy_o, 0);
    for (int k = 0; k < NPORT; k++) begin
      check("rnd_leftover", q[k].size(), 0);
      check("rnd_count", delivered[k] - base[k], 100);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/any1_fu_result_xmit.md
ANY1_FU_RESULT_XMIT -- requirements
Module: any1_fu_result_xmit

Interface
REQ-001 The block SHALL have parameter NPORT, default 4, meaning the number of functional-unit result sources (port 0 = FU_EXEC, 1 = FU_MUL, 2 = FU_DIV, 3 = FU_MEM).
REQ-002 The block SHALL have parameter DEPTH, default 2, meaning the per-port result FIFO depth; it is a power of two and at least 2.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port flush_i, input, 1 bit: pipeline flush that discards all buffered results.
REQ-006 The block SHALL have port fu_v_i, input, NPORT bits: per-port result valid.
REQ-007 The block SHALL have port fu_rdy_o, output, NPORT bits: per-port ready.
REQ-008 The block SHALL have port fu_i, input, NPORT x sFuncUnit: per-port result record (cmt, rid, ele, res, cause, badAddr).
REQ-009 The block SHALL have port rob_v_o, output, 1 bit: the outgoing record is valid.
REQ-010 The block SHALL have port rob_rdy_i, input, 1 bit: the reorder buffer accepts the record.
REQ-011 The block SHALL have port rob_o, output, sFuncUnit: the outgoing result record.
REQ-012 The block SHALL have port busy_o, output, 1 bit: high when any FIFO is non-empty or rob_v_o is high.

Function
REQ-013 A port SHALL push fu_i[k] into FIFO k on any edge where fu_v_i[k] && fu_rdy_o[k] && !flush_i.
REQ-014 fu_rdy_o[k] SHALL be the registered value of (FIFO k count < DEPTH), with no combinational path from rob_rdy_i or fu_v_i.
REQ-015 A push and a pop SHALL be allowed on the same FIFO in the same cycle; the count is then unchanged.
REQ-016 Read and write pointers SHALL be log2(DEPTH) bits, wrap modulo DEPTH, with a separate count of log2(DEPTH)+1 bits.
REQ-017 The output register SHALL be loadable in a cycle when !rob_v_o || rob_rdy_i.
REQ-018 When the output register is loadable, the block SHALL grant exactly one non-empty FIFO, pop it, and load its head into rob_o with rob_v_o=1.
REQ-019 If no FIFO is non-empty while the register is loadable, rob_v_o SHALL go to 0 on the next edge.
REQ-020 Arbitration SHALL be round-robin:
- search order starts at port (last_grant+1) mod NPORT;
- last_grant updates only on a grant;
- its reset value is NPORT-1, so port 0 has first priority.
REQ-021 While rob_v_o=1 && !rob_rdy_i, rob_o SHALL hold stable and no FIFO SHALL be popped.
REQ-022 Minimum latency SHALL be one cycle: a result pushed at edge N appears on rob_o after edge N+1, when its FIFO was empty and the port wins arbitration.
REQ-023 Records SHALL pass bit-exact; within a port, order SHALL be preserved.
REQ-024 flush_i=1 at edge N SHALL clear all FIFO counts and pointers and rob_v_o, drop that cycle's inputs, and leave last_grant unchanged.
REQ-025 When flush_i and rob_rdy_i are both high, the held record SHALL count as delivered; no new record is loaded.
REQ-026 busy_o SHALL be combinational from current state only.

Reset
REQ-027 On rst_i=1 at an edge, the block SHALL set the following, overriding flush_i and all inputs:
- all FIFO pointers and counts to 0;
- rob_v_o=0 and rob_o=0;
- fu_rdy_o=all ones;
- last_grant=NPORT-1.
REQ-028 A reset asserted mid-transfer SHALL discard all held and buffered records; none SHALL appear after reset.

Verification
REQ-029 The bench SHALL cover single result: port 2 pushes rid=5, res=64'h1234, with rob_rdy_i=1 -> rob_v_o=1 with rid=5 exactly one cycle later, then 0.
REQ-030 The bench SHALL cover fairness: all four ports push one record each in the same cycle, with rob_rdy_i=1 -> output order is ports 0,1,2,3 on four consecutive cycles.
REQ-031 The bench SHALL cover backpressure: rob_rdy_i=0 while port 1 pushes 3 records -> rob_o holds the first record, fu_rdy_o[1]=0 after FIFO fills (DEPTH=2), and no record is lost or reordered once rob_rdy_i=1.
REQ-032 The bench SHALL cover flush: flush_i=1 with two buffered records and rob_v_o=1 -> next cycle rob_v_o=0, busy_o=0, fu_rdy_o all ones, and no stale record is emitted afterwards.
REQ-033 The bench SHALL cover reset mid-stream: rst_i pulsed while port 3 is streaming with rob_rdy_i toggling -> all outputs are at reset values the next cycle, and the first post-reset grant goes to the lowest non-empty port.
REQ-034 The bench SHALL cover wrap: 100 random pushes per port with random rob_rdy_i -> a scoreboard shows per-port order preserved and every record delivered exactly once.
